// File: rtl/ysyx_22040895_lsu_pkg.sv
// Shared encodings for the ysyx_22040895 load/store unit: access sizes,
// FSM states, the default data width and small lane-mask helpers.
// Build option: YSYX_22040895_MISALIGN_CHECK_EN (used by the align sub-module).
`ifndef YSYX_22040895_XLEN
`define YSYX_22040895_XLEN 64
`endif

package ysyx_22040895_lsu_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10,
        SIZE_D = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_WAIT = 2'b10,
        S_RESP = 2'b11
    } state_e;

    localparam int XLEN_DEFAULT = `YSYX_22040895_XLEN;

    // Byte-enable pattern of an access before it is shifted into its lanes.
    function automatic logic [7:0] size_byte_mask(input size_e size);
        case (size)
            SIZE_B:  return 8'h01;
            SIZE_H:  return 8'h03;
            SIZE_W:  return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    // Bit-level keep mask of an access; callers truncate it to XLEN.
    function automatic logic [63:0] size_bit_mask(input size_e size);
        case (size)
            SIZE_B:  return 64'h0000_0000_0000_00FF;
            SIZE_H:  return 64'h0000_0000_0000_FFFF;
            SIZE_W:  return 64'h0000_0000_FFFF_FFFF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_22040895_lsu_align.sv
// Combinational lane logic for the LSU: store byte mask and data lane
// shift, natural-alignment check, and load lane extraction with sign/zero
// extension.
// Build option: YSYX_22040895_MISALIGN_CHECK_EN enables st_misalign_o;
// without it the flag is tied low and misaligned lanes simply truncate.
module ysyx_22040895_lsu_align
    import ysyx_22040895_lsu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [$clog2(XLEN/8)-1:0] st_off_i,
    input  size_e                     st_size_i,
    input  logic [XLEN-1:0]           st_wdata_i,
    output logic [XLEN-1:0]           st_wdata_o,
    output logic [XLEN/8-1:0]         st_mask_o,
    output logic                      st_misalign_o,
    input  logic [$clog2(XLEN/8)-1:0] ld_off_i,
    input  size_e                     ld_size_i,
    input  logic                      ld_unsigned_i,
    input  logic [XLEN-1:0]           ld_rdata_i,
    output logic [XLEN-1:0]           ld_data_o
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    logic [XLEN-1:0] st_keep;
    logic [15:0]     st_mask_wide;
    logic [XLEN-1:0] ld_lane;
    logic [XLEN-1:0] ld_keep;
    logic            ld_sign;

    // Store path: drop bits above the access size, then move into the addressed lanes.
    always_comb begin
        st_keep      = XLEN'(size_bit_mask(st_size_i));
        st_wdata_o   = (st_wdata_i & st_keep) << {st_off_i, 3'b000};
        st_mask_wide = {8'h00, size_byte_mask(st_size_i)} << st_off_i;
        st_mask_o    = st_mask_wide[NB-1:0];
    end

`ifdef YSYX_22040895_MISALIGN_CHECK_EN
    logic [7:0]       align_wide;
    logic [OFF_W-1:0] align_mask;

    // An access is aligned when the offset bits below its size are zero.
    always_comb begin
        align_wide    = (8'd1 << st_size_i) - 8'd1;
        align_mask    = align_wide[OFF_W-1:0];
        st_misalign_o = |(st_off_i & align_mask);
    end
`else
    assign st_misalign_o = 1'b0;
`endif

    // Load path: bring the addressed lane to bit 0, truncate, then extend.
    always_comb begin
        ld_lane = ld_rdata_i >> {ld_off_i, 3'b000};
        ld_keep = XLEN'(size_bit_mask(ld_size_i));
        case (ld_size_i)
            SIZE_B:  ld_sign = ld_lane[7];
            SIZE_H:  ld_sign = ld_lane[15];
            SIZE_W:  ld_sign = ld_lane[31];
            default: ld_sign = ld_lane[XLEN-1];
        endcase
        ld_data_o = ld_lane & ld_keep;
        if (!ld_unsigned_i && ld_sign) begin
            ld_data_o = ld_data_o | ~ld_keep;
        end
    end

endmodule

// File: rtl/ysyx_22040895_lsu.sv
// Multi-cycle load/store unit between execute and writeback. One operation
// per core handshake; memory accessed through a request/response port with
// a timeout. Passthrough operations return the execute result in one cycle.
// Build option: YSYX_22040895_MISALIGN_CHECK_EN rejects misaligned accesses
// with resp_err_o instead of issuing them to memory.
//
// state  | meaning
// IDLE   | ready for a new operation
// REQ    | mem_ce_o high, waiting for mem_ready_i
// WAIT   | load issued, waiting for mem_rvalid_i
// RESP   | response held until resp_ready_i
module ysyx_22040895_lsu
    import ysyx_22040895_lsu_pkg::*;
#(
    parameter int XLEN    = XLEN_DEFAULT,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_sl_i,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [XLEN-1:0]   req_addr_i,
    input  logic [XLEN-1:0]   req_wdata_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [XLEN-1:0]   resp_data_o,
    output logic              resp_err_o,
    output logic              mem_ce_o,
    input  logic              mem_ready_i,
    output logic              mem_we_o,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    output logic [XLEN/8-1:0] mem_wmask_o,
    input  logic              mem_rvalid_i,
    input  logic [XLEN-1:0]   mem_rdata_i
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             we_q;
    size_e            size_q;
    logic             unsigned_q;
    logic [OFF_W-1:0] off_q;
    logic             mem_ce_q;
    logic [XLEN-1:0]  mem_addr_q;
    logic [XLEN-1:0]  mem_wdata_q;
    logic [NB-1:0]    mem_wmask_q;
    logic             resp_valid_q;
    logic [XLEN-1:0]  resp_data_q;
    logic             resp_err_q;

    size_e            req_size;
    logic [OFF_W-1:0] req_off;
    logic [XLEN-1:0]  st_wdata;
    logic [NB-1:0]    st_mask;
    logic             st_misalign;
    logic [XLEN-1:0]  ld_data;
    logic             size_illegal;
    logic             reject;
    logic             timeout_hit;

    assign req_size = size_e'(req_size_i);
    assign req_off  = req_addr_i[OFF_W-1:0];

    ysyx_22040895_lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .st_off_i      (req_off),
        .st_size_i     (req_size),
        .st_wdata_i    (req_wdata_i),
        .st_wdata_o    (st_wdata),
        .st_mask_o     (st_mask),
        .st_misalign_o (st_misalign),
        .ld_off_i      (off_q),
        .ld_size_i     (size_q),
        .ld_unsigned_i (unsigned_q),
        .ld_rdata_i    (mem_rdata_i),
        .ld_data_o     (ld_data)
    );

    // Double-word accesses do not exist on a 32-bit datapath; misalignment
    // is only flagged when the check is built in.
    assign size_illegal = (XLEN == 32) && (req_size == SIZE_D);
    assign reject       = size_illegal | st_misalign;

    // The cycle that would take the count to TIMEOUT is the last one allowed.
    assign cnt_d       = cnt_q + 1'b1;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

    // Operation sequencing with all handshake and datapath outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            size_q       <= SIZE_B;
            unsigned_q   <= 1'b0;
            off_q        <= '0;
            mem_ce_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wmask_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        we_q       <= req_we_i;
                        size_q     <= req_size;
                        unsigned_q <= req_unsigned_i;
                        off_q      <= req_off;
                        if (!req_sl_i) begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_data_q  <= req_addr_i;
                            resp_err_q   <= 1'b0;
                        end else if (reject) begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_data_q  <= '0;
                            resp_err_q   <= 1'b1;
                        end else begin
                            state_q     <= S_REQ;
                            cnt_q       <= '0;
                            mem_ce_q    <= 1'b1;
                            mem_addr_q  <= {req_addr_i[XLEN-1:OFF_W], {OFF_W{1'b0}}};
                            mem_wdata_q <= req_we_i ? st_wdata : '0;
                            mem_wmask_q <= req_we_i ? st_mask : '0;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ready_i) begin
                        mem_ce_q <= 1'b0;
                        if (we_q) begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_data_q  <= '0;
                            resp_err_q   <= 1'b0;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= '0;
                        end
                    end else if (timeout_hit) begin
                        mem_ce_q     <= 1'b0;
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_data_q  <= '0;
                        resp_err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid_i) begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_data_q  <= ld_data;
                        resp_err_q   <= 1'b0;
                    end else if (timeout_hit) begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_data_q  <= '0;
                        resp_err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_RESP: begin
                    if (resp_ready_i) begin
                        state_q      <= S_IDLE;
                        resp_valid_q <= 1'b0;
                        resp_data_q  <= '0;
                        resp_err_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Ready is withheld for the whole reset window, not just until the first edge.
    assign req_ready_o  = (state_q == S_IDLE) && !rst;
    assign resp_valid_o = resp_valid_q;
    assign resp_data_o  = resp_data_q;
    assign resp_err_o   = resp_err_q;
    assign mem_ce_o     = mem_ce_q;
    assign mem_we_o     = mem_ce_q & we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign mem_wmask_o  = mem_wmask_q;

endmodule

// File: doc/ysyx_22040895_lsu.md
Name: ysyx_22040895_lsu

Overview:
Parametrised multi-cycle load/store unit that replaces the single-cycle combinational memory stage between the execute stage and regfile writeback. It accepts one operation per request/response handshake from the core and drives an external data-memory port with a separate request/response handshake. It generates byte-lane masks for stores, and aligns and sign/zero-extends load data. Non-memory operations pass the execute result straight through.

Parameters:
XLEN, 64, data and address width; legal values are 32 or 64.
TIMEOUT, 255, maximum cycles to wait for memory in REQ or WAIT before flagging an error; 0 disables the timeout.
CNT_W, 8, width of the timeout counter; must satisfy TIMEOUT < 2^CNT_W.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
req_valid_i  in  1  core operation valid
req_ready_o  out  1  LSU can accept an operation
req_sl_i  in  1  1 = load/store, 0 = passthrough
req_we_i  in  1  1 = store, 0 = load (when req_sl_i=1)
req_size_i  in  2  00 byte, 01 half, 10 word, 11 double (11 is illegal when XLEN=32)
req_unsigned_i  in  1  zero-extend loads
req_addr_i  in  XLEN  execute result / effective address
req_wdata_i  in  XLEN  store data, right-aligned
resp_valid_o  out  1  response valid
resp_ready_i  in  1  core accepts the response
resp_data_o  out  XLEN  writeback data
resp_err_o  out  1  timeout or misalignment error
mem_ce_o  out  1  memory request valid
mem_ready_i  in  1  memory accepts the request
mem_we_o  out  1  store request
mem_addr_o  out  XLEN  address aligned to XLEN/8 bytes
mem_wdata_o  out  XLEN  store data shifted into its byte lanes
mem_wmask_o  out  XLEN/8  byte-enable mask
mem_rvalid_i  in  1  read data valid
mem_rdata_i  in  XLEN  aligned read data

Behaviour:
- States: IDLE, REQ, WAIT, RESP. Reset forces IDLE asynchronously. While in reset, all outputs are 0, except req_ready_o, which is 1 once rst deasserts.
- req_ready_o = (state == IDLE). An operation is accepted on req_valid_i & req_ready_o; all request fields are registered on that edge.
- IDLE, passthrough accept → RESP with resp_data_o = req_addr_i and resp_err_o = 0. This gives 1-cycle latency.
- IDLE, memory accept → REQ.
- REQ: mem_ce_o = 1, and address, data, mask and we stay stable until mem_ready_i.
  - Store with mem_ready_i → RESP, resp_data_o = 0.
  - Load with mem_ready_i → WAIT.
- WAIT: on mem_rvalid_i, capture the lane (mem_rdata_i >> 8*addr[log2(XLEN/8)-1:0]), truncate it to the requested size, and sign- or zero-extend it to XLEN → RESP.
- mem_rvalid_i is ignored outside WAIT. mem_rvalid_i arriving in the same cycle as mem_ready_i does not complete the load; data must arrive in WAIT.
- RESP: resp_valid_o = 1 and resp_data_o/resp_err_o stay stable until resp_ready_i; on resp_ready_i → IDLE. There is no same-cycle re-accept, so throughput is at most one operation per 2 cycles for passthrough.
- Store mask = (2^(2^size) - 1) << addr_low. wdata is replicated/shifted into the matching lanes.
- Timeout: the counter clears on entry to REQ and to WAIT and increments each cycle in those states. When count == TIMEOUT (TIMEOUT > 0) → RESP with resp_err_o = 1, resp_data_o = 0, and mem_ce_o drops.
- A response that arrives after a timeout is dropped. Late mem_rvalid_i is ignored because the FSM is no longer in WAIT.
- Reset mid-transaction aborts immediately: mem_ce_o = 0, no response is produced.
- size = 11 with XLEN = 32 → RESP with resp_err_o = 1, no memory access.

Optional Feature:
YSYX_22040895_MISALIGN_CHECK_EN.
- Defined: a memory operation whose address is not naturally aligned to its size goes IDLE → RESP with resp_err_o = 1, resp_data_o = 0, and mem_ce_o is never asserted.
- Undefined: misaligned addresses are issued to memory unchecked. Lanes that would cross the XLEN boundary are simply truncated by the shift/mask.

Decomposition:
- Shared define file holds:
  - size encodings (SIZE_B/H/W/D)
  - FSM state encodings (2 bits)
  - the XLEN default macro
- One natural sub-module, ysyx_22040895_lsu_align: purely combinational. It produces the store mask and wdata lane shift, plus load extraction and sign/zero-extension.

Test Plan:
- Passthrough: req_sl_i=0, addr=0x1234, resp_ready_i=1 → resp_valid_o the cycle after accept, resp_data_o=0x1234, resp_err_o=0.
- Store byte: addr=0x1003, wdata=0xAB, size=00 → mem_addr_o=0x1000, mem_wmask_o=0x08, mem_wdata_o[31:24]=0xAB. Hold mem_ready_i=0 for 3 cycles; outputs stay stable, then resp follows.
- Signed half load: addr=0x2002, mem_rdata_i=0x0000_0000_8001_0000, rvalid 2 cycles after ready → resp_data_o=0xFFFF_FFFF_FFFF_8001. Repeat with unsigned → 0x8001.
- Timeout: TIMEOUT=4, mem_ready_i held 0 → resp_err_o=1 in RESP, mem_ce_o deasserted after 4 cycles in REQ. A late rvalid is ignored.
- Back-pressure plus reset: hold resp_ready_i=0 for 5 cycles → resp held stable and req_ready_o=0. Assert rst during WAIT → IDLE immediately, mem_ce_o=0.
- Misalign (macro defined): word load at 0x1002 → resp_err_o=1, mem_ce_o never asserted. With the macro undefined → memory access issued.
